// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, types and write-priority helper for the
//                two-write / two-read register file with busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry: 32 registers of 32 bits.
    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_AW = 5;

    // Architectural zero register: reads as 0, never busy, writes dropped.
    localparam int ZERO_REG = 0;

    // Which write port (if any) supplies the value for a given register.
    typedef enum logic [1:0] {
        WSEL_NONE = 2'd0,
        WSEL_P0   = 2'd1,
        WSEL_P1   = 2'd2
    } wsel_e;

    // Port 1 carries the younger result, so it wins when both ports hit.
    function automatic wsel_e wr_resolve(input logic hit_0, input logic hit_1);
        wsel_e sel;
        if (hit_1) begin
            sel = WSEL_P1;
        end else if (hit_0) begin
            sel = WSEL_P0;
        end else begin
            sel = WSEL_NONE;
        end
        return sel;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits. Issue marks a destination busy,
//                write-back clears it; a same-cycle set beats a clear.
//                Bit 0 (zero register) is never busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr_we_0,
    input  logic [AW-1:0]         i_clr_addr_0,
    input  logic                  i_clr_we_1,
    input  logic [AW-1:0]         i_clr_addr_1,
    input  logic                  i_set_valid,
    input  logic [AW-1:0]         i_set_addr,
    output logic [(1<<AW)-1:0]    o_busy_vec
);

    localparam int c_DEPTH = 1 << AW;

    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_set;
    logic [c_DEPTH-1:0] w_clr;
    logic [c_DEPTH-1:0] w_keep_mask;

    // One-hot decode of the set request and the two clear requests.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_valid) begin
            w_set[i_set_addr] = 1'b1;
        end
        if (i_clr_we_0) begin
            w_clr[i_clr_addr_0] = 1'b1;
        end
        if (i_clr_we_1) begin
            w_clr[i_clr_addr_1] = 1'b1;
        end
    end

    // Everything except the zero register may hold a busy bit.
    always_comb begin
        w_keep_mask           = '1;
        w_keep_mask[ZERO_REG] = 1'b0;
    end

    // Clear first, then OR in the set so a new producer stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & w_keep_mask;
        end
    end

    assign o_busy_vec = r_busy;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2w2r_sb
//  Description : Register file with two combinational read ports, two
//                synchronous write ports, optional write-to-read bypass and
//                a busy scoreboard for RAW hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int DW     = DEFAULT_DW,
    parameter int AW     = DEFAULT_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         reg_R_addr_A,
    input  logic [AW-1:0]         reg_R_addr_B,
    output logic [DW-1:0]         rdata_A,
    output logic [DW-1:0]         rdata_B,
    output logic                  busy_A,
    output logic                  busy_B,
    input  logic [AW-1:0]         reg_W_addr_0,
    input  logic [DW-1:0]         wdata_0,
    input  logic                  reg_we_0,
    input  logic [AW-1:0]         reg_W_addr_1,
    input  logic [DW-1:0]         wdata_1,
    input  logic                  reg_we_1,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  issue_valid,
    output logic [(1<<AW)-1:0]    busy_vec
);

    localparam int            c_DEPTH     = 1 << AW;
    localparam logic [AW-1:0] c_ZERO_ADDR = AW'(ZERO_REG);

    logic [DW-1:0]      r_mem [c_DEPTH];
    logic               w_wr_ok_0;
    logic               w_wr_ok_1;
    logic               w_issue_ok;
    logic [c_DEPTH-1:0] w_busy_vec;
    logic [AW-1:0]      w_raddr [2];
    logic [DW-1:0]      w_rdata [2];

    // Writes and issues aimed at the zero register are dropped up front.
    assign w_wr_ok_0  = reg_we_0    && (reg_W_addr_0 != c_ZERO_ADDR);
    assign w_wr_ok_1  = reg_we_1    && (reg_W_addr_1 != c_ZERO_ADDR);
    assign w_issue_ok = issue_valid && (issue_addr   != c_ZERO_ADDR);

    // Storage update: each register picks its source through the shared
    // priority helper so the array and the bypass agree on dual writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < c_DEPTH; i++) begin
                case (wr_resolve(w_wr_ok_0 && (reg_W_addr_0 == AW'(i)),
                                 w_wr_ok_1 && (reg_W_addr_1 == AW'(i))))
                    WSEL_P1: r_mem[i] <= wdata_1;
                    WSEL_P0: r_mem[i] <= wdata_0;
                    default: ;
                endcase
            end
        end
    end

    assign w_raddr[0] = reg_R_addr_A;
    assign w_raddr[1] = reg_R_addr_B;

    // Identical read path for both ports: stored value, optionally
    // overridden by a same-cycle write to the same address.
    for (genvar p = 0; p < 2; p++) begin : g_read_port
        logic [DW-1:0] w_stored;
        wsel_e         w_sel;

        assign w_stored = (w_raddr[p] == c_ZERO_ADDR) ? '0 : r_mem[w_raddr[p]];

        if (BYPASS) begin : g_bypass
            // Write enables already exclude address 0, so no zero check here.
            assign w_sel = wr_resolve(w_wr_ok_0 && (reg_W_addr_0 == w_raddr[p]),
                                      w_wr_ok_1 && (reg_W_addr_1 == w_raddr[p]));
        end else begin : g_no_bypass
            assign w_sel = WSEL_NONE;
        end

        assign w_rdata[p] = (w_sel == WSEL_P1) ? wdata_1 :
                            (w_sel == WSEL_P0) ? wdata_0 :
                                                 w_stored;
    end

    assign rdata_A = w_rdata[0];
    assign rdata_B = w_rdata[1];

    regfile_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_clr_we_0   (w_wr_ok_0),
        .i_clr_addr_0 (reg_W_addr_0),
        .i_clr_we_1   (w_wr_ok_1),
        .i_clr_addr_1 (reg_W_addr_1),
        .i_set_valid  (w_issue_ok),
        .i_set_addr   (issue_addr),
        .o_busy_vec   (w_busy_vec)
    );

    // Busy lookups use the registered vector only; bit 0 is always clear.
    assign busy_A   = w_busy_vec[reg_R_addr_A];
    assign busy_B   = w_busy_vec[reg_R_addr_B];
    assign busy_vec = w_busy_vec;

endmodule : regfile_2w2r_sb
`default_nettype wire

// File: tb/tb_regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_2w2r_sb
//  Description : Directed self-checking bench; drives a bypassing and a
//                non-bypassing instance with identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2w2r_sb;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_AW-1:0] ra, rb, wa0, wa1, iaddr;
    logic [c_DW-1:0] wd0, wd1;
    logic            we0, we1, ivalid;

    logic [c_DW-1:0] rda_b, rdb_b, rda_n, rdb_n;
    logic            ba_b, bb_b, ba_n, bb_n;
    logic [31:0]     bv_b, bv_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2w2r_sb #(.DW(c_DW), .AW(c_AW), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst),
        .reg_R_addr_A(ra), .reg_R_addr_B(rb),
        .rdata_A(rda_b), .rdata_B(rdb_b), .busy_A(ba_b), .busy_B(bb_b),
        .reg_W_addr_0(wa0), .wdata_0(wd0), .reg_we_0(we0),
        .reg_W_addr_1(wa1), .wdata_1(wd1), .reg_we_1(we1),
        .issue_addr(iaddr), .issue_valid(ivalid), .busy_vec(bv_b)
    );

    regfile_2w2r_sb #(.DW(c_DW), .AW(c_AW), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst),
        .reg_R_addr_A(ra), .reg_R_addr_B(rb),
        .rdata_A(rda_n), .rdata_B(rdb_n), .busy_A(ba_n), .busy_B(bb_n),
        .reg_W_addr_0(wa0), .wdata_0(wd0), .reg_we_0(we0),
        .reg_W_addr_1(wa1), .wdata_1(wd1), .reg_we_1(we1),
        .issue_addr(iaddr), .issue_valid(ivalid), .busy_vec(bv_n)
    );

    // Advance one edge; inputs change 1 time unit after posedge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        we0 = 1'b0; we1 = 1'b0; ivalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; idle(); ra = '0; rb = '0; wa0 = '0; wa1 = '0;
        wd0 = '0; wd1 = '0; iaddr = '0;
        tick(); tick();
        rst = 1'b0;
        ra = 5'd5; rb = 5'd31;
        #1;
        checks++; if (rda_b !== 32'h0) begin errors++; $display("FAIL reset_rdA got %h want %h", rda_b, 32'h0); end
        checks++; if (rdb_b !== 32'h0) begin errors++; $display("FAIL reset_rdB got %h want %h", rdb_b, 32'h0); end
        checks++; if (bv_b !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want %h", bv_b, 32'h0); end
        checks++; if (bv_n !== 32'h0) begin errors++; $display("FAIL reset_busy_nb got %h want %h", bv_n, 32'h0); end
    endtask

    task automatic test_basic_write;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
        tick(); idle();
        ra = 5'd3; #1;
        checks++; if (rda_n !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_r3 got %h want %h", rda_n, 32'hDEADBEEF); end
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234;
        ra = 5'd0; #1;
        checks++; if (rda_b !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h want %h", rda_b, 32'h0); end
        tick(); idle(); #1;
        checks++; if (rda_b !== 32'h0) begin errors++; $display("FAIL r0_read got %h want %h", rda_b, 32'h0); end
        checks++; if (bv_b !== 32'h0) begin errors++; $display("FAIL r0_write_busy got %h want %h", bv_b, 32'h0); end
    endtask

    task automatic test_dual_write;
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBBBB;
        ra = 5'd7; #1;
        checks++; if (rda_b !== 32'hBBBB) begin errors++; $display("FAIL dual_bypass got %h want %h", rda_b, 32'hBBBB); end
        checks++; if (rda_n !== 32'h0) begin errors++; $display("FAIL dual_nobypass got %h want %h", rda_n, 32'h0); end
        tick(); idle(); #1;
        checks++; if (rda_b !== 32'hBBBB) begin errors++; $display("FAIL dual_stored got %h want %h", rda_b, 32'hBBBB); end
        checks++; if (rda_n !== 32'hBBBB) begin errors++; $display("FAIL dual_stored_nb got %h want %h", rda_n, 32'hBBBB); end
    endtask

    task automatic test_bypass;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11;
        tick(); idle();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h22;
        rb = 5'd9; #1;
        checks++; if (rdb_b !== 32'h22) begin errors++; $display("FAIL bypass_on got %h want %h", rdb_b, 32'h22); end
        checks++; if (rdb_n !== 32'h11) begin errors++; $display("FAIL bypass_off got %h want %h", rdb_n, 32'h11); end
        tick(); idle(); #1;
        checks++; if (rdb_b !== 32'h22) begin errors++; $display("FAIL bypass_next got %h want %h", rdb_b, 32'h22); end
        checks++; if (rdb_n !== 32'h22) begin errors++; $display("FAIL bypass_next_nb got %h want %h", rdb_n, 32'h22); end
    endtask

    task automatic test_back_to_back;
        we0 = 1'b1; wa0 = 5'd13; wd0 = 32'h1;
        we1 = 1'b1; wa1 = 5'd14; wd1 = 32'h2;
        ra = 5'd13; rb = 5'd14; #1;
        checks++; if (rda_b !== 32'h1 || rdb_b !== 32'h2) begin errors++; $display("FAIL b2b_bypass got %h %h want 1 2", rda_b, rdb_b); end
        tick();
        we0 = 1'b0; we1 = 1'b1; wa1 = 5'd13; wd1 = 32'h3; #1;
        checks++; if (rda_b !== 32'h3) begin errors++; $display("FAIL b2b_p1_bypass got %h want %h", rda_b, 32'h3); end
        checks++; if (rda_n !== 32'h1 || rdb_n !== 32'h2) begin errors++; $display("FAIL b2b_stored got %h %h want 1 2", rda_n, rdb_n); end
        tick(); idle(); #1;
        checks++; if (rda_n !== 32'h3) begin errors++; $display("FAIL b2b_final got %h want %h", rda_n, 32'h3); end
    endtask

    task automatic test_scoreboard;
        ivalid = 1'b1; iaddr = 5'd4; ra = 5'd4; rb = 5'd0; #1;
        checks++; if (ba_b !== 1'b0) begin errors++; $display("FAIL sb_no_early got %b want 0", ba_b); end
        tick(); idle(); #1;
        checks++; if (ba_b !== 1'b1) begin errors++; $display("FAIL sb_set got %b want 1", ba_b); end
        checks++; if (bv_b !== 32'h10) begin errors++; $display("FAIL sb_vec got %h want %h", bv_b, 32'h10); end
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44; #1;
        checks++; if (ba_b !== 1'b1) begin errors++; $display("FAIL sb_clr_early got %b want 1", ba_b); end
        tick(); idle(); #1;
        checks++; if (ba_b !== 1'b0) begin errors++; $display("FAIL sb_clr got %b want 0", ba_b); end
        checks++; if (rda_n !== 32'h44) begin errors++; $display("FAIL sb_clr_data got %h want %h", rda_n, 32'h44); end
        ivalid = 1'b1; iaddr = 5'd4; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h99;
        tick(); idle(); #1;
        checks++; if (ba_n !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", ba_n); end
        checks++; if (rda_n !== 32'h99) begin errors++; $display("FAIL sb_set_data got %h want %h", rda_n, 32'h99); end
        ivalid = 1'b1; iaddr = 5'd0;
        tick(); idle(); #1;
        checks++; if (bv_b !== 32'h10 || bb_b !== 1'b0) begin errors++; $display("FAIL sb_r0 got %h %b want 10 0", bv_b, bb_b); end
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h99;
        tick(); idle(); #1;
        checks++; if (bv_b !== 32'h0) begin errors++; $display("FAIL sb_drain got %h want %h", bv_b, 32'h0); end
    endtask

    task automatic test_reset_mid;
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h55; ivalid = 1'b1; iaddr = 5'd10;
        tick(); idle();
        ra = 5'd10; rb = 5'd3; #1;
        checks++; if (rda_n !== 32'h55 || bv_n !== 32'h400) begin errors++; $display("FAIL mid_pre got %h %h want 55 400", rda_n, bv_n); end
        rst = 1'b1; we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h66; ivalid = 1'b1; iaddr = 5'd11;
        tick(); rst = 1'b0; idle(); #1;
        checks++; if (rda_n !== 32'h0) begin errors++; $display("FAIL mid_r10 got %h want %h", rda_n, 32'h0); end
        checks++; if (bv_b !== 32'h0) begin errors++; $display("FAIL mid_busy got %h want %h", bv_b, 32'h0); end
        checks++; if (rdb_b !== 32'h0) begin errors++; $display("FAIL mid_r3 got %h want %h", rdb_b, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_dual_write();
        test_bypass();
        test_back_to_back();
        test_scoreboard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_2w2r_sb
`default_nettype wire
